ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//   ID/EX pipeline register plus operand-forwarding network for the 5-stage MIPS core.
//   Captures decoded fields, then drives the ALU operands and op code in EX.
//   Resolves RAW hazards from EX/MEM and MEM/WB. Honours stall and flush from the hazard unit.
// PARAMETERS
//   DATA_W   32  datapath width
//   RADDR_W   5  register-file address width
//   OP_W      4  ALU operation code width
// PORTS
//   clk            in   1        rising-edge clock
//   rst            in   1        synchronous, active-high reset
//   stall          in   1        hold ID/EX contents (freshen forwarded data)
//   flush          in   1        insert bubble into EX
//   id_valid       in   1        ID slot holds a real instruction
//   id_rs_addr     in   RADDR_W  source register rs
//   id_rt_addr     in   RADDR_W  source register rt
//   id_rd_addr     in   RADDR_W  destination register (already rt/rd-selected)
//   id_rs_data     in   DATA_W   register-file read of rs
//   id_rt_data     in   DATA_W   register-file read of rt
//   id_imm         in   DATA_W   immediate, already sign/zero-extended by ID
//   id_shamt       in   5        shift amount field
//   id_alu_op      in   OP_W     ALU op code (shared ALU_* constants)
//   id_a_shamt     in   1        operand A = zero-extended shamt (SLL/SRL)
//   id_b_imm       in   1        operand B = id_imm instead of rt
//   id_reg_write   in   1        instruction writes the register file
//   mem_reg_write  in   1        EX/MEM stage writes a register
//   mem_rd_addr    in   RADDR_W  EX/MEM destination
//   mem_result     in   DATA_W   EX/MEM ALU result
//   wb_reg_write   in   1        MEM/WB stage writes a register
//   wb_rd_addr     in   RADDR_W  MEM/WB destination
//   wb_data        in   DATA_W   MEM/WB write-back value
//   alu_a          out  DATA_W   ALU inputA
//   alu_b          out  DATA_W   ALU inputB
//   alu_op         out  OP_W     ALU operation
//   ex_store_data  out  DATA_W   forwarded rt value (store data path)
//   ex_rd_addr     out  RADDR_W  registered destination
//   ex_reg_write   out  1        registered write enable, gated by ex_valid
//   ex_valid       out  1        EX slot holds a real instruction
// BEHAVIOUR
//   - Reset: all registered fields 0. ex_valid=0, ex_reg_write=0, alu_op=0.
//     Outputs then read alu_a=0, alu_b=0, ex_store_data=0.
//   - Latency: ID fields captured at edge N. alu_a/alu_b/alu_op valid combinationally
//     in cycle N+1.
//   - Update priority per edge: rst > flush > stall > normal capture.
//   - flush: register loads a bubble: all fields 0, ex_valid=0. Wins over a simultaneous stall.
//   - stall (no flush): control fields and addresses hold. Stored rs/rt data fields reload
//     with the current forwarded values. A WB-forwarded value that leaves the pipe during a
//     multi-cycle stall is therefore retained.
//   - Forwarding per source operand (rs, rt), combinational from registered fields:
//     - Priority 1, MEM: if mem_reg_write && mem_rd_addr==addr && addr!=0, use mem_result.
//     - Priority 2, WB: else if wb_reg_write && wb_rd_addr==addr && addr!=0, use wb_data.
//     - Otherwise use the stored register data.
//     - Register $0 is never forwarded. Its value is the stored data (0 from the RF).
//   - Operand A: a_shamt ? {27'b0,shamt} : fwd_rs.
//   - Operand B: b_imm ? imm : fwd_rt. ex_store_data = fwd_rt always.
//   - ex_reg_write = reg_write_q & ex_valid. ex_rd_addr = rd_q.
//   - Forwarding checks do not qualify on ex_valid: bubbles carry zeroed addresses.
//   - Load-use hazards are detected upstream. This block only obeys stall/flush.
// STRUCTURE
//   - Shared header Constants.vh: ALU_* op codes, DATA_W/RADDR_W defaults, REG_ZERO.
//   - One sub-module, fwd_mux: combinational 3-way select with the priority above.
//     Instantiated twice (rs, rt).
//   - Top level holds the ID/EX register and the A/B selects.
// TESTING
//   1. rst=1 for 2 cycles, then idle -> ex_valid=0, alu_a=alu_b=0, ex_reg_write=0.
//   2. Capture add: rs=1(0x5), rt=2(0x7), no hazards -> next cycle alu_a=5, alu_b=7,
//      alu_op=ALU_ADD.
//   3. Priority: rs=3 with mem_rd=3 (0xAA) and wb_rd=3 (0xBB) both writing -> alu_a=0xAA.
//      Drop mem_reg_write -> 0xBB.
//   4. rs=0 with mem_rd=0, mem_reg_write=1, mem_result=0xFF -> alu_a=0 (no forward from $0).
//   5. Stall hold: rt=4 forwarded from WB (0x1234); stall 3 cycles, wb stage changes to rd=9
//      -> alu_b stays 0x1234. Control fields unchanged.
//   6. flush and stall asserted together, then SLL with shamt=4, rt=0x1 -> first bubble
//      (ex_valid=0). Then alu_a=4, alu_b=1, alu_op=ALU_SLL.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the EX operand stage: default widths, ALU op codes, register $0.
package ex_operand_stage_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_RADDR_W = 5;
  localparam int unsigned DEF_OP_W    = 4;
  localparam int unsigned SHAMT_W     = 5;

  localparam logic [DEF_RADDR_W-1:0] REG_ZERO = '0;

  localparam logic [DEF_OP_W-1:0] ALU_AND = 4'd0;
  localparam logic [DEF_OP_W-1:0] ALU_OR  = 4'd1;
  localparam logic [DEF_OP_W-1:0] ALU_ADD = 4'd2;
  localparam logic [DEF_OP_W-1:0] ALU_SLL = 4'd3;
  localparam logic [DEF_OP_W-1:0] ALU_SRL = 4'd4;
  localparam logic [DEF_OP_W-1:0] ALU_XOR = 4'd5;
  localparam logic [DEF_OP_W-1:0] ALU_SUB = 4'd6;
  localparam logic [DEF_OP_W-1:0] ALU_SLT = 4'd7;
  localparam logic [DEF_OP_W-1:0] ALU_NOR = 4'd12;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Three-way operand forwarding select: EX/MEM result, then MEM/WB data, then stored RF data.
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RADDR_W = DEF_RADDR_W
) (
  input  logic [RADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0]  i_reg_data,
  input  logic               i_mem_reg_write,
  input  logic [RADDR_W-1:0] i_mem_rd_addr,
  input  logic [DATA_W-1:0]  i_mem_result,
  input  logic               i_wb_reg_write,
  input  logic [RADDR_W-1:0] i_wb_rd_addr,
  input  logic [DATA_W-1:0]  i_wb_data,
  output logic [DATA_W-1:0]  o_data_c
);

  logic w_nonzero;
  logic w_hit_mem;
  logic w_hit_wb;

  // $0 is hardwired, so a matching write to it must never be forwarded
  assign w_nonzero = (i_addr != '0);
  assign w_hit_mem = i_mem_reg_write && (i_mem_rd_addr == i_addr) && w_nonzero;
  assign w_hit_wb  = i_wb_reg_write && (i_wb_rd_addr == i_addr) && w_nonzero;

  always_comb begin
    o_data_c = i_reg_data;
    if (w_hit_mem) begin
      o_data_c = i_mem_result;
    end else if (w_hit_wb) begin
      o_data_c = i_wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with rs/rt forwarding and ALU operand selection for the EX stage.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RADDR_W = DEF_RADDR_W,
  parameter int unsigned OP_W    = DEF_OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [SHAMT_W-1:0] id_shamt,
  input  logic [OP_W-1:0]    id_alu_op,
  input  logic               id_a_shamt,
  input  logic               id_b_imm,
  input  logic               id_reg_write,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_valid
);

  logic               r_valid;
  logic               r_reg_write;
  logic               r_a_shamt;
  logic               r_b_imm;
  logic [OP_W-1:0]    r_alu_op;
  logic [RADDR_W-1:0] r_rs_addr;
  logic [RADDR_W-1:0] r_rt_addr;
  logic [RADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0]  r_rs_data;
  logic [DATA_W-1:0]  r_rt_data;
  logic [DATA_W-1:0]  r_imm;
  logic [SHAMT_W-1:0] r_shamt;

  logic [DATA_W-1:0]  w_fwd_rs;
  logic [DATA_W-1:0]  w_fwd_rt;

  // ID/EX register; a stall refreshes the data fields so a WB value leaving the pipe is kept
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_a_shamt   <= 1'b0;
      r_b_imm     <= 1'b0;
      r_alu_op    <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
    end else if (stall) begin
      r_rs_data   <= w_fwd_rs;
      r_rt_data   <= w_fwd_rt;
    end else begin
      r_valid     <= id_valid;
      r_reg_write <= id_reg_write;
      r_a_shamt   <= id_a_shamt;
      r_b_imm     <= id_b_imm;
      r_alu_op    <= id_alu_op;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rd_addr   <= id_rd_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_shamt     <= id_shamt;
    end
  end

  ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
    .i_addr          (r_rs_addr),
    .i_reg_data      (r_rs_data),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_rd_addr   (mem_rd_addr),
    .i_mem_result    (mem_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd_addr    (wb_rd_addr),
    .i_wb_data       (wb_data),
    .o_data_c        (w_fwd_rs)
  );

  ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
    .i_addr          (r_rt_addr),
    .i_reg_data      (r_rt_data),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_rd_addr   (mem_rd_addr),
    .i_mem_result    (mem_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd_addr    (wb_rd_addr),
    .i_wb_data       (wb_data),
    .o_data_c        (w_fwd_rt)
  );

  assign alu_a         = r_a_shamt ? DATA_W'(r_shamt) : w_fwd_rs;
  assign alu_b         = r_b_imm ? r_imm : w_fwd_rt;
  assign alu_op        = r_alu_op;
  assign ex_store_data = w_fwd_rt;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_reg_write  = r_reg_write & r_valid;
  assign ex_valid      = r_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: capture, forwarding priority, $0, stall hold, flush.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid, id_a_shamt, id_b_imm, id_reg_write;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_alu_op;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_data;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
    .id_a_shamt(id_a_shamt), .id_b_imm(id_b_imm), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_a_shamt = 0; id_b_imm = 0; id_reg_write = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_shamt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_op = 0;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0;
    clear_id(); clear_fwd();
    tick(); tick();
    rst = 0;
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %h exp 0", ex_valid); end
    tests++; if (alu_a !== 32'h0) begin fails++; $display("FAIL reset_alu_a got %h exp 0", alu_a); end
    tests++; if (alu_b !== 32'h0) begin fails++; $display("FAIL reset_alu_b got %h exp 0", alu_b); end
    tests++; if (ex_reg_write !== 1'b0) begin fails++; $display("FAIL reset_reg_write got %h exp 0", ex_reg_write); end
    tests++; if (alu_op !== 4'h0) begin fails++; $display("FAIL reset_alu_op got %h exp 0", alu_op); end
    tests++; if (ex_store_data !== 32'h0) begin fails++; $display("FAIL reset_store got %h exp 0", ex_store_data); end
  endtask

  task automatic test_add();
    id_valid = 1; id_reg_write = 1; id_alu_op = ALU_ADD;
    id_rs_addr = 5'd1; id_rs_data = 32'h5; id_rt_addr = 5'd2; id_rt_data = 32'h7; id_rd_addr = 5'd3;
    tick();
    clear_id();
    tests++; if (alu_a !== 32'h5) begin fails++; $display("FAIL add_alu_a got %h exp 5", alu_a); end
    tests++; if (alu_b !== 32'h7) begin fails++; $display("FAIL add_alu_b got %h exp 7", alu_b); end
    tests++; if (alu_op !== ALU_ADD) begin fails++; $display("FAIL add_alu_op got %h exp %h", alu_op, ALU_ADD); end
    tests++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin fails++; $display("FAIL add_ctrl got v=%b w=%b exp 1 1", ex_valid, ex_reg_write); end
    tests++; if (ex_rd_addr !== 5'd3) begin fails++; $display("FAIL add_rd got %0d exp 3", ex_rd_addr); end
    tests++; if (ex_store_data !== 32'h7) begin fails++; $display("FAIL add_store got %h exp 7", ex_store_data); end
  endtask

  task automatic test_priority();
    id_valid = 1; id_alu_op = ALU_OR; id_rs_addr = 5'd3; id_rs_data = 32'h11;
    id_rt_addr = 5'd6; id_rt_data = 32'h22; id_b_imm = 1; id_imm = 32'h100;
    mem_reg_write = 1; mem_rd_addr = 5'd3; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd_addr = 5'd3; wb_data = 32'hBB;
    tick();
    clear_id();
    tests++; if (alu_a !== 32'hAA) begin fails++; $display("FAIL prio_mem got %h exp aa", alu_a); end
    tests++; if (alu_b !== 32'h100) begin fails++; $display("FAIL prio_imm got %h exp 100", alu_b); end
    tests++; if (ex_store_data !== 32'h22) begin fails++; $display("FAIL prio_store_rf got %h exp 22", ex_store_data); end
    mem_reg_write = 0; #1;
    tests++; if (alu_a !== 32'hBB) begin fails++; $display("FAIL prio_wb got %h exp bb", alu_a); end
    wb_rd_addr = 5'd6; mem_reg_write = 1; mem_rd_addr = 5'd7; #1;
    tests++; if (alu_a !== 32'h11) begin fails++; $display("FAIL prio_rf got %h exp 11", alu_a); end
    tests++; if (ex_store_data !== 32'hBB) begin fails++; $display("FAIL prio_store_wb got %h exp bb", ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_zero_reg();
    id_valid = 1; id_alu_op = ALU_ADD; id_rs_addr = 5'd0; id_rs_data = 32'h0;
    id_rt_addr = 5'd0; id_rt_data = 32'h0;
    mem_reg_write = 1; mem_rd_addr = 5'd0; mem_result = 32'hFF;
    wb_reg_write = 1; wb_rd_addr = 5'd0; wb_data = 32'hEE;
    tick();
    clear_id();
    tests++; if (alu_a !== 32'h0) begin fails++; $display("FAIL zero_alu_a got %h exp 0", alu_a); end
    tests++; if (alu_b !== 32'h0) begin fails++; $display("FAIL zero_alu_b got %h exp 0", alu_b); end
    clear_fwd();
  endtask

  task automatic test_stall();
    id_valid = 1; id_reg_write = 1; id_alu_op = ALU_SUB; id_rd_addr = 5'd6;
    id_rs_addr = 5'd5; id_rs_data = 32'h9; id_rt_addr = 5'd4; id_rt_data = 32'h0;
    wb_reg_write = 1; wb_rd_addr = 5'd4; wb_data = 32'h1234;
    tick();
    tests++; if (alu_b !== 32'h1234) begin fails++; $display("FAIL stall_pre got %h exp 1234", alu_b); end
    stall = 1;
    id_alu_op = ALU_OR; id_rd_addr = 5'd8; id_rt_addr = 5'd7; id_rt_data = 32'h5555; id_reg_write = 0;
    tick();
    wb_rd_addr = 5'd9; wb_data = 32'hDEAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (alu_b !== 32'h1234) begin fails++; $display("FAIL stall_hold_b[%0d] got %h exp 1234", i, alu_b); end
    end
    tests++; if (alu_op !== ALU_SUB || ex_rd_addr !== 5'd6) begin fails++; $display("FAIL stall_ctrl got op=%h rd=%0d exp %h 6", alu_op, ex_rd_addr, ALU_SUB); end
    tests++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin fails++; $display("FAIL stall_valid got v=%b w=%b exp 1 1", ex_valid, ex_reg_write); end
    tests++; if (alu_a !== 32'h9) begin fails++; $display("FAIL stall_alu_a got %h exp 9", alu_a); end
    stall = 0; clear_id(); clear_fwd();
  endtask

  task automatic test_flush_sll();
    id_valid = 1; id_reg_write = 1; id_alu_op = ALU_ADD; id_rs_addr = 5'd1; id_rs_data = 32'h77; id_rd_addr = 5'd2;
    flush = 1; stall = 1;
    tick();
    tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin fails++; $display("FAIL flush_bubble got v=%b w=%b exp 0 0", ex_valid, ex_reg_write); end
    tests++; if (alu_op !== 4'h0 || alu_a !== 32'h0 || ex_rd_addr !== 5'd0) begin fails++; $display("FAIL flush_fields got op=%h a=%h rd=%0d exp 0 0 0", alu_op, alu_a, ex_rd_addr); end
    flush = 0; stall = 0; clear_id();
    id_valid = 1; id_reg_write = 1; id_alu_op = ALU_SLL; id_a_shamt = 1; id_shamt = 5'd4;
    id_rs_addr = 5'd0; id_rt_addr = 5'd2; id_rt_data = 32'h1; id_rd_addr = 5'd10;
    tick();
    clear_id();
    tests++; if (alu_a !== 32'h4) begin fails++; $display("FAIL sll_alu_a got %h exp 4", alu_a); end
    tests++; if (alu_b !== 32'h1) begin fails++; $display("FAIL sll_alu_b got %h exp 1", alu_b); end
    tests++; if (alu_op !== ALU_SLL || ex_valid !== 1'b1) begin fails++; $display("FAIL sll_ctrl got op=%h v=%b exp %h 1", alu_op, ex_valid, ALU_SLL); end
  endtask

  task automatic test_back_to_back();
    id_valid = 1; id_alu_op = ALU_XOR; id_rs_addr = 5'd8; id_rs_data = 32'hA0; id_rt_addr = 5'd9; id_rt_data = 32'hB0;
    tick();
    tests++; if (alu_a !== 32'hA0 || alu_b !== 32'hB0) begin fails++; $display("FAIL b2b_first got a=%h b=%h exp a0 b0", alu_a, alu_b); end
    id_alu_op = ALU_AND; id_rs_addr = 5'd9; id_rs_data = 32'h1; id_rt_addr = 5'd8; id_rt_data = 32'h2;
    mem_reg_write = 1; mem_rd_addr = 5'd8; mem_result = 32'hCAFE;
    tick();
    clear_id();
    tests++; if (alu_a !== 32'h1 || alu_b !== 32'hCAFE) begin fails++; $display("FAIL b2b_second got a=%h b=%h exp 1 cafe", alu_a, alu_b); end
    tests++; if (alu_op !== ALU_AND) begin fails++; $display("FAIL b2b_op got %h exp %h", alu_op, ALU_AND); end
    clear_fwd();
    rst = 1; tick(); rst = 0;
    tests++; if (ex_valid !== 1'b0 || alu_b !== 32'h0) begin fails++; $display("FAIL b2b_reset got v=%b b=%h exp 0 0", ex_valid, alu_b); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_priority();
    test_zero_reg();
    test_stall();
    test_flush_sll();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
